uart_rx_buffered: RTL and testbench
===================================

Name: uart_rx_buffered

Overview:
- Serial receive front-end between the FPGA_SERIAL_RX pin and the CPU's memory-mapped UART receive register.
- Synchronises the raw line, deframes 8N1 bytes, and queues them in a small FIFO so the CPU can drain them at its own pace.
- Decouples software polling latency from line rate; reports overflow and framing errors through sticky flags.

Parameters:
- CLOCK_FREQ, 71_428_571: clk frequency in Hz (the CPU clock).
- BAUD_RATE, 115_200: line rate in bit/s.
- FIFO_DEPTH, 8: byte entries; power of 2, ≥2.

Ports:
- clk  in  1  CPU clock
- rst  in  1  synchronous, active-high reset
- serial_in  in  1  raw RX pin, asynchronous, idles high
- data_out  out  8  head-of-FIFO byte
- data_out_valid  out  1  FIFO non-empty
- data_out_ready  in  1  consumer pop; a byte is consumed on valid&&ready
- count  out  $clog2(FIFO_DEPTH)+1  bytes currently queued
- overflow  out  1  sticky: a byte was dropped because the FIFO was full
- frame_err  out  1  sticky: a stop bit was sampled low
- clear_flags  in  1  single-cycle pulse that clears overflow and frame_err

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - data_out_valid=0, count=0, overflow=0, frame_err=0.
  - data_out=0 (don't-care while valid=0).
  - Synchroniser flops=1; FSM in IDLE.
- Timing constants:
  - SYMBOL_EDGE_TIME = CLOCK_FREQ/BAUD_RATE (integer divide).
  - SAMPLE_TIME = SYMBOL_EDGE_TIME/2.
  - Bit counter width is $clog2(SYMBOL_EDGE_TIME).
- Synchroniser: two-flop synchroniser on serial_in; all logic uses the synchronised value rx_s.
- FSM states IDLE, START, DATA, STOP:
  - IDLE: rx_s==0 → START, cycle counter=0.
  - START: when counter==SAMPLE_TIME-1: rx_s==0 → DATA, counter=0, bit index=0; rx_s==1 → IDLE (glitch reject).
  - DATA: when counter==SYMBOL_EDGE_TIME-1, sample rx_s into shift register LSB-first, counter=0. After bit index 7 → STOP.
  - STOP: when counter==SYMBOL_EDGE_TIME-1, sample the stop bit, issue a push request, → IDLE. The next start edge can be detected in the following cycle, so there is no dead half-bit.
- Push latency: byte is visible on data_out with data_out_valid=1 exactly one cycle after the stop-bit sample cycle.
- FIFO:
  - First-word-fall-through: data_out always equals the head entry.
  - Circular read and write pointers wrap modulo FIFO_DEPTH.
  - Push accepted if not full, or if a pop occurs in the same cycle (full with simultaneous pop and push: count unchanged, order preserved).
  - Push while full with no pop: byte dropped, overflow←1.
  - Pop while empty: ignored, no state change.
  - Simultaneous push and pop when empty: the pop is ignored; count becomes 1.
- Sticky flags: clear_flags clears both flags. If a set event coincides with clear_flags, the set wins.
- Reset mid-frame: the partial byte is discarded and the FIFO is emptied; the line is re-acquired at the next falling edge after rst deasserts.

Optional Feature:
- Macro: UART_RX_FRAME_ERR_EN.
- Defined:
  - Stop bit sampled 0 → byte discarded (no push), frame_err←1.
  - FSM returns to IDLE, which re-arms on the still-low line.
- Undefined:
  - Stop bit is not checked; the byte is always pushed.
  - frame_err is tied to 0. The port remains present.

Decomposition:
- Package uart_pkg:
  - FSM state enum.
  - DATA_BITS=8.
  - Constant functions for SYMBOL_EDGE_TIME and SAMPLE_TIME.
- Sub-module uart_rx_fifo: synchronous FWFT FIFO with parameter DEPTH; ports push, push_data, pop, head, empty, full, count.
- Deframer FSM and sticky flags live in uart_rx_buffered.

Test Plan:
All scenarios use CLOCK_FREQ=1000, BAUD_RATE=100 (10 cycles/bit).
1. Drive byte 0xA5 (8N1) with data_out_ready=0 → data_out=0xA5, valid=1, count=1 within 98 cycles of the start edge; overflow=0, frame_err=0.
2. Pull serial_in low for 3 cycles, then high → no byte, count stays 0, FSM back in IDLE, and a following 0x3C is received correctly.
3. FIFO_DEPTH=4, ready=0, send 0x01..0x05 → count=4, bytes popped in order 01,02,03,04; 0x05 lost; overflow=1; clear_flags pulse → overflow=0.
4. Send 0x3C with stop bit driven 0:
   - Macro defined: frame_err=1, count=0.
   - Macro undefined: data_out=0x3C, frame_err=0.
5. Assert rst for 1 cycle during data bit 4 of 0x77 → valid=0, count=0 next cycle; a subsequent 0x5A is received exactly.
6. FIFO full (depth 4), ready=1 held and a 5th byte arriving in the pop cycle → count stays 4, no overflow, order preserved; back-to-back bytes with no idle gap are all received.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and timing helpers for the buffered UART receiver.
package uart_pkg;

   localparam int DATA_BITS = 8;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } rx_state_t;

   function automatic int symbol_edge_time(input int clock_freq, input int baud_rate);
      return clock_freq / baud_rate;
   endfunction

   function automatic int sample_time(input int clock_freq, input int baud_rate);
      return symbol_edge_time(clock_freq, baud_rate) / 2;
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO; a push is accepted when full only if a pop
// happens in the same cycle.
module uart_rx_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_pop;
   logic             w_push;

   assign empty  = (r_count == '0);
   assign full   = (r_count == FULL_COUNT);
   assign count  = r_count;
   assign w_pop  = pop && !empty;
   assign w_push = push && (!full || w_pop);
   // Mask the head while empty so the output reads zero instead of stale data.
   assign head   = empty ? '0 : r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_buffered.sv
// 8N1 UART receiver feeding a FWFT FIFO, with sticky overflow/framing flags.
// Define UART_RX_FRAME_ERR_EN to drop bytes whose stop bit samples low.
module uart_rx_buffered
   import uart_pkg::*;
#(
   parameter int CLOCK_FREQ = 71_428_571,
   parameter int BAUD_RATE  = 115_200,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          serial_in,
   output logic [7:0]                    data_out,
   output logic                          data_out_valid,
   input  logic                          data_out_ready,
   output logic [$clog2(FIFO_DEPTH):0]   count,
   output logic                          overflow,
   output logic                          frame_err,
   input  logic                          clear_flags
);

   localparam int SYMBOL_EDGE_TIME = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
   localparam int SAMPLE_TIME      = sample_time(CLOCK_FREQ, BAUD_RATE);
   localparam int CW               = $clog2(SYMBOL_EDGE_TIME);
   localparam int BW               = $clog2(DATA_BITS);
   localparam logic [CW-1:0] SYM_LAST    = CW'(SYMBOL_EDGE_TIME - 1);
   localparam logic [CW-1:0] SAMPLE_LAST = CW'(SAMPLE_TIME - 1);
   localparam logic [BW-1:0] BIT_LAST    = BW'(DATA_BITS - 1);

   logic                 r_sync1;
   logic                 r_sync2;
   rx_state_t            r_state;
   logic [CW-1:0]        r_cnt;
   logic [BW-1:0]        r_bit_idx;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_overflow;

   rx_state_t            w_state_next;
   logic [CW-1:0]        w_cnt_next;
   logic [BW-1:0]        w_bit_idx_next;
   logic [DATA_BITS-1:0] w_shift_next;
   logic                 w_rx_s;
   logic                 w_push;
   logic                 w_stop_sample;
   logic                 w_fifo_empty;
   logic                 w_fifo_full;
   logic                 w_overflow_set;

   assign w_rx_s = r_sync2;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1   <= 1'b1;
         r_sync2   <= 1'b1;
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
      end else begin
         r_sync1   <= serial_in;
         r_sync2   <= r_sync1;
         r_state   <= w_state_next;
         r_cnt     <= w_cnt_next;
         r_bit_idx <= w_bit_idx_next;
         r_shift   <= w_shift_next;
      end
   end

   always_comb begin
      w_state_next   = r_state;
      w_cnt_next     = r_cnt + 1'b1;
      w_bit_idx_next = r_bit_idx;
      w_shift_next   = r_shift;
      w_stop_sample  = 1'b0;
      unique case (r_state)
         IDLE: begin
            w_cnt_next = '0;
            if (!w_rx_s) begin
               w_state_next = START;
            end
         end
         START: begin
            if (r_cnt == SAMPLE_LAST) begin
               w_cnt_next = '0;
               if (!w_rx_s) begin
                  w_state_next   = DATA;
                  w_bit_idx_next = '0;
               end else begin
                  w_state_next = IDLE;
               end
            end
         end
         DATA: begin
            if (r_cnt == SYM_LAST) begin
               w_cnt_next     = '0;
               w_shift_next   = {w_rx_s, r_shift[DATA_BITS-1:1]};
               w_bit_idx_next = r_bit_idx + 1'b1;
               if (r_bit_idx == BIT_LAST) begin
                  w_state_next = STOP;
               end
            end
         end
         STOP: begin
            if (r_cnt == SYM_LAST) begin
               w_cnt_next    = '0;
               w_stop_sample = 1'b1;
               w_state_next  = IDLE;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

`ifdef UART_RX_FRAME_ERR_EN
   logic r_frame_err;

   assign w_push    = w_stop_sample && w_rx_s;
   assign frame_err = r_frame_err;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_frame_err <= 1'b0;
      end else begin
         r_frame_err <= (w_stop_sample && !w_rx_s) || (r_frame_err && !clear_flags);
      end
   end
`else
   assign w_push    = w_stop_sample;
   assign frame_err = 1'b0;
`endif

   // A full FIFO always has a head, so a drop happens exactly when nobody pops.
   assign w_overflow_set = w_push && w_fifo_full && !data_out_ready;
   assign overflow       = r_overflow;
   assign data_out_valid = !w_fifo_empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_overflow <= 1'b0;
      end else begin
         r_overflow <= w_overflow_set || (r_overflow && !clear_flags);
      end
   end

   uart_rx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_BITS)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (w_push),
      .push_data (r_shift),
      .pop       (data_out_ready),
      .head      (data_out),
      .empty     (w_fifo_empty),
      .full      (w_fifo_full),
      .count     (count)
   );

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Directed bench for uart_rx_buffered at 10 clocks per bit with a 4-entry FIFO.
module tb_uart_rx_buffered;
   import uart_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       serial_in;
   logic [7:0] data_out;
   logic       data_out_valid;
   logic       data_out_ready;
   logic [2:0] count;
   logic       overflow;
   logic       frame_err;
   logic       clear_flags;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   uart_rx_buffered #(
      .CLOCK_FREQ (1000),
      .BAUD_RATE  (100),
      .FIFO_DEPTH (4)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .serial_in      (serial_in),
      .data_out       (data_out),
      .data_out_valid (data_out_valid),
      .data_out_ready (data_out_ready),
      .count          (count),
      .overflow       (overflow),
      .frame_err      (frame_err),
      .clear_flags    (clear_flags)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drives the first ncyc clocks of an 8N1 frame; optionally raises ready for
   // exactly the clock edge on which the receiver samples the stop bit.
   task automatic send(input logic [7:0] d, input logic stop_bit, input int ncyc,
                       input bit pulse_ready);
      logic [9:0] fr;
      fr = {stop_bit, d, 1'b0};
      for (int c = 0; c < ncyc; c++) begin
         serial_in = fr[c/10];
         if (pulse_ready && c == 97) data_out_ready = 1'b1;
         if (pulse_ready && c == 98) data_out_ready = 1'b0;
         @(posedge clk);
         #1;
      end
      serial_in = 1'b1;
   endtask

   task automatic pop_chk(input string tag, input logic [7:0] exp);
      chk(tag, data_out, exp);
      chk({tag, "_valid"}, data_out_valid, 1'b1);
      data_out_ready = 1'b1;
      tick(1);
      data_out_ready = 1'b0;
   endtask

   initial begin
      rst            = 1'b1;
      serial_in      = 1'b1;
      data_out_ready = 1'b0;
      clear_flags    = 1'b0;
      tick(3);
      rst = 1'b0;
      tick(1);
      chk("rst_valid", data_out_valid, 1'b0);
      chk("rst_count", count, 3'd0);
      chk("rst_ovf", overflow, 1'b0);
      chk("rst_ferr", frame_err, 1'b0);
      chk("rst_data", data_out, 8'h00);
      chk("rst_state", dut.r_state, IDLE);
      tick(5);

      // single byte
      send(8'hA5, 1'b1, 100, 1'b0);
      chk("t1_data", data_out, 8'hA5);
      chk("t1_valid", data_out_valid, 1'b1);
      chk("t1_count", count, 3'd1);
      chk("t1_ovf", overflow, 1'b0);
      chk("t1_ferr", frame_err, 1'b0);
      pop_chk("t1_pop", 8'hA5);
      chk("t1_empty", count, 3'd0);

      // short low glitch must be rejected
      send(8'h00, 1'b1, 3, 1'b0);
      tick(20);
      chk("t2_count", count, 3'd0);
      chk("t2_valid", data_out_valid, 1'b0);
      chk("t2_state", dut.r_state, IDLE);
      send(8'h3C, 1'b1, 100, 1'b0);
      chk("t2_count1", count, 3'd1);
      pop_chk("t2_pop", 8'h3C);

      // overflow with back-to-back frames
      for (int i = 1; i <= 5; i++) send(8'(i), 1'b1, 100, 1'b0);
      chk("t3_count", count, 3'd4);
      chk("t3_ovf", overflow, 1'b1);
      pop_chk("t3_pop1", 8'h01);
      pop_chk("t3_pop2", 8'h02);
      pop_chk("t3_pop3", 8'h03);
      pop_chk("t3_pop4", 8'h04);
      chk("t3_empty_valid", data_out_valid, 1'b0);
      chk("t3_empty_count", count, 3'd0);
      chk("t3_ovf_held", overflow, 1'b1);
      clear_flags = 1'b1;
      tick(1);
      clear_flags = 1'b0;
      chk("t3_ovf_clr", overflow, 1'b0);

      // stop bit driven low
      send(8'h3C, 1'b0, 100, 1'b0);
      tick(10);
`ifdef UART_RX_FRAME_ERR_EN
      chk("t4_ferr", frame_err, 1'b1);
      chk("t4_count", count, 3'd0);
      clear_flags = 1'b1;
      tick(1);
      clear_flags = 1'b0;
      chk("t4_ferr_clr", frame_err, 1'b0);
`else
      chk("t4_ferr", frame_err, 1'b0);
      chk("t4_count", count, 3'd1);
      pop_chk("t4_pop", 8'h3C);
`endif

      // reset in the middle of data bit 4, with a byte already queued
      send(8'h99, 1'b1, 100, 1'b0);
      chk("t5_pre_count", count, 3'd1);
      send(8'h77, 1'b1, 55, 1'b0);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      chk("t5_valid", data_out_valid, 1'b0);
      chk("t5_count", count, 3'd0);
      tick(30);
      chk("t5_idle_count", count, 3'd0);
      send(8'h5A, 1'b1, 100, 1'b0);
      chk("t5_count1", count, 3'd1);
      pop_chk("t5_pop", 8'h5A);

      // full FIFO, pop coincides with the fifth push
      send(8'h11, 1'b1, 100, 1'b0);
      send(8'h22, 1'b1, 100, 1'b0);
      send(8'h33, 1'b1, 100, 1'b0);
      send(8'h44, 1'b1, 100, 1'b0);
      chk("t6_full", count, 3'd4);
      send(8'h55, 1'b1, 100, 1'b1);
      chk("t6_count", count, 3'd4);
      chk("t6_ovf", overflow, 1'b0);
      pop_chk("t6_pop1", 8'h22);
      pop_chk("t6_pop2", 8'h33);
      pop_chk("t6_pop3", 8'h44);
      pop_chk("t6_pop4", 8'h55);
      chk("t6_empty", count, 3'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
